// File: rtl/cmp_bist_pkg.sv
// Shared types and constants for the comparator self-test sequencer.
// The settle counter is fixed at 4 bits, so SETTLE may be 1..15.
package cmp_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned SETTLE_CNT_W = 4;

  // The counter runs from SETTLE-1 down to 0, which gives exactly SETTLE cycles.
  function automatic logic [SETTLE_CNT_W-1:0] settle_load(input int unsigned settle);
    return SETTLE_CNT_W'(settle - 1);
  endfunction

endpackage

// File: rtl/cmp_bist_sweep.sv
// Operand pair counter for the sweep. {a,b} steps as a single 2*WIDTH-bit
// count with b as the low part; last flags the all-ones pair.
module cmp_bist_sweep #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             last
);

  logic [2*WIDTH-1:0] pair_q;
  logic [2*WIDTH-1:0] pair_d;

  assign last  = &pair_q;
  assign a_out = pair_q[2*WIDTH-1:WIDTH];
  assign b_out = pair_q[WIDTH-1:0];

  // The count stops at the last pair; it never wraps back to (0,0).
  always_comb begin
    pair_d = pair_q;
    if (clr) begin
      pair_d = '0;
    end else if (inc && !last) begin
      pair_d = pair_q + (2*WIDTH)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
    end else begin
      pair_q <= pair_d;
    end
  end

endmodule

// File: rtl/cmp_bist.sv
// Self-test sequencer for a WIDTH-bit greater-than comparator: sweeps all
// operand pairs, counts gt mismatches and captures the first failing pair.
module cmp_bist
  import cmp_bist_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gt_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  state_e                  state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [ERR_W-1:0]        err_q, err_d;
  logic                    fv_q, fv_d;
  logic [WIDTH-1:0]        fa_q, fa_d;
  logic [WIDTH-1:0]        fb_q, fb_d;

  logic sweep_clr;
  logic sweep_inc;
  logic last_pair;
  logic launch;
  logic check_en;
  logic exp_gt;
  logic mismatch;
  logic [ERR_W-1:0] err_inc;

  cmp_bist_sweep #(
    .WIDTH(WIDTH)
  ) u_sweep (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (sweep_clr),
    .inc  (sweep_inc),
    .a_out(a_out),
    .b_out(b_out),
    .last (last_pair)
  );

  // State register and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_SETTLE;
      ST_SETTLE:        if (cnt_q == '0) state_d = ST_CHECK;
      ST_CHECK:         state_d = last_pair ? ST_DONE : ST_SETTLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    launch    = 1'b0;
    check_en  = 1'b0;
    sweep_clr = 1'b0;
    sweep_inc = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        launch    = start;
        sweep_clr = start;
      end
      ST_CHECK: begin
        check_en  = 1'b1;
        sweep_inc = !last_pair;
      end
      default: ;
    endcase
  end

  assign exp_gt   = (a_out > b_out);
  assign mismatch = check_en && (gt_in != exp_gt);
  assign err_inc  = (&err_q) ? err_q : err_q + ERR_W'(1);

  // Settle counter and result datapath.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_q;
    fv_d   = fv_q;
    fa_d   = fa_q;
    fb_d   = fb_q;
    if (launch) begin
      cnt_d  = settle_load(SETTLE);
      busy_d = 1'b1;
      done_d = 1'b0;
      pass_d = 1'b0;
      err_d  = '0;
      fv_d   = 1'b0;
      fa_d   = '0;
      fb_d   = '0;
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q != '0) cnt_d = cnt_q - SETTLE_CNT_W'(1);
    end else if (check_en) begin
      if (mismatch) begin
        err_d = err_inc;
        if (!fv_q) begin
          fv_d = 1'b1;
          fa_d = a_out;
          fb_d = b_out;
        end
      end
      if (last_pair) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        // Zero after the final check means no pair ever mismatched, since the count saturates.
        pass_d = (err_d == '0);
      end else begin
        cnt_d = settle_load(SETTLE);
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;

endmodule

// File: tb/tb_cmp_bist.sv
// Self-checking bench for cmp_bist: table of comparator fault patterns,
// random fault masks scored by a pair-list model, plus timing/reset sequences.
module tb_cmp_bist;

  localparam int W      = 2;
  localparam int S      = 1;
  localparam int NPAIRS = 1 << (2 * W);
  localparam int SWEEP  = NPAIRS * (S + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic gt_in;
  logic gt2;
  logic [1:0]  mode = 2'd0;   // 0: golden xor mask, 1: stuck-0, 2: stuck-1
  logic [15:0] mask = 16'h0;

  logic [W-1:0] a_out, b_out, fail_a, fail_b;
  logic busy, done, pass, fail_valid;
  logic [7:0] err_count;

  logic [W-1:0] a2, b2, fa2, fb2;
  logic busy2, done2, pass2, fv2;
  logic [1:0] err2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign gt_in = (mode == 2'd1) ? 1'b0 :
                 (mode == 2'd2) ? 1'b1 :
                 ((a_out > b_out) ^ mask[{a_out, b_out}]);
  assign gt2 = 1'b1;

  cmp_bist #(.WIDTH(W), .SETTLE(S), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gt_in(gt_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b)
  );

  cmp_bist #(.WIDTH(W), .SETTLE(S), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .gt_in(gt2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2)
  );

  typedef struct {
    int          md;
    logic [15:0] msk;
    int          err;
    int          fv;
    int          fa;
    int          fb;
    int          ps;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected results from the list of faulty pairs in sweep order.
  function automatic vec_t model(input logic [15:0] m);
    vec_t v;
    int cnt = 0;
    int first = -1;
    for (int i = 0; i < NPAIRS; i++) begin
      if (m[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    v.md  = 0;
    v.msk = m;
    v.err = (cnt > 255) ? 255 : cnt;
    v.fv  = (cnt > 0) ? 1 : 0;
    v.fa  = (first < 0) ? 0 : first / (1 << W);
    v.fb  = (first < 0) ? 0 : first % (1 << W);
    v.ps  = (cnt == 0) ? 1 : 0;
    return v;
  endfunction

  // Pulses start, then follows the sweep edge by edge until done (bounded).
  task automatic run_sweep(input bit glitch, input bit steps, output int n);
    int j = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    forever begin
      if (steps) begin
        int p;
        p = (j < SWEEP) ? j / (S + 1) : NPAIRS - 1;
        chk($sformatf("step%0d_a", j), int'(a_out), p / (1 << W));
        chk($sformatf("step%0d_b", j), int'(b_out), p % (1 << W));
        chk($sformatf("step%0d_busy", j), int'(busy), (j < SWEEP) ? 1 : 0);
      end
      if (done) break;
      if (j >= 200) begin
        chk("sweep_timeout", j, SWEEP);
        break;
      end
      start = (glitch && (j + 1 == 5 || j + 1 == 20)) ? 1'b1 : 1'b0;
      @(posedge clk);
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    n = j;
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err_count), v.err);
    chk({tag, "_pass"}, int'(pass), v.ps);
    chk({tag, "_fv"}, int'(fail_valid), v.fv);
    chk({tag, "_fa"}, int'(fail_a), v.fa);
    chk({tag, "_fb"}, int'(fail_b), v.fb);
    chk({tag, "_a_hold"}, int'(a_out), (1 << W) - 1);
    chk({tag, "_b_hold"}, int'(b_out), (1 << W) - 1);
  endtask

  initial begin
    int n;
    int stray;
    vec_t v;

    tbl[0] = '{1, 16'h0000, 6, 1, 1, 0, 0};
    tbl[1] = '{2, 16'h0000, 10, 1, 0, 0, 0};
    tbl[2] = '{0, 16'h8000, 1, 1, 3, 3, 0};
    tbl[3] = '{0, 16'h0000, 0, 0, 0, 0, 1};
    tbl[4] = '{0, 16'hFFFF, 16, 1, 0, 0, 0};
    for (int i = 5; i < 10; i++) begin
      if (i % 2 == 0) tbl[i] = model(16'(1 << $urandom_range(0, 15)));
      else            tbl[i] = model(16'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_ab", int'({a_out, b_out}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    mode = 2'd0; mask = 16'h0;
    run_sweep(1'b0, 1'b1, n);
    chk("t1_latency", n, SWEEP);
    chk_result("t1", model(16'h0));
    $display("sweep golden: cycles=%0d err=%0d pass=%0d", n, err_count, pass);

    for (int i = 0; i < 10; i++) begin
      mode = 2'(tbl[i].md);
      mask = tbl[i].msk;
      run_sweep(1'b0, 1'b0, n);
      chk($sformatf("tbl%0d_latency", i), n, SWEEP);
      chk_result($sformatf("tbl%0d", i), tbl[i]);
      $display("sweep %0d: mode=%0d mask=%h cycles=%0d err=%0d fv=%0d fa=%0d fb=%0d pass=%0d",
               i, mode, mask, n, err_count, fail_valid, fail_a, fail_b, pass);
    end

    chk("sat_done", int'(done2), 1);
    chk("sat_err", int'(err2), 3);
    chk("sat_pass", int'(pass2), 0);
    chk("sat_fv", int'(fv2), 1);
    chk("sat_fa", int'(fa2), 0);
    chk("sat_fb", int'(fb2), 0);
    $display("saturating sweep: err=%0d pass=%0d", err2, pass2);

    mode = 2'd1;
    run_sweep(1'b1, 1'b0, n);
    chk("glitch_latency", n, SWEEP);
    chk_result("glitch", tbl[0]);
    $display("sweep with start glitches: cycles=%0d err=%0d", n, err_count);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("restart_done", int'(done), 0);
    chk("restart_err", int'(err_count), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_fv", int'(fail_valid), 0);
    chk("restart_ab", int'({a_out, b_out}), 0);
    $display("restart from done: busy=%0d a=%0d b=%0d", busy, a_out, b_out);

    repeat (SWEEP + 4) @(negedge clk);
    mode = 2'd0; mask = 16'h0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    chk("prerst_a", int'(a_out), 1);
    chk("prerst_b", int'(b_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_ab", int'({a_out, b_out}), 0);
    chk("async_done", int'(done), 0);
    chk("async_err", int'(err_count), 0);
    chk("async_fail", int'({fail_valid, fail_a, fail_b}), 0);
    @(negedge clk); rst_n = 1'b1;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || done || a_out != 0 || b_out != 0) stray++;
    end
    chk("post_rst_idle", stray, 0);
    $display("reset mid-sweep: busy=%0d done=%0d a=%0d b=%0d", busy, done, a_out, b_out);

    run_sweep(1'b0, 1'b0, n);
    chk("post_rst_latency", n, SWEEP);
    v = model(16'h0);
    chk_result("post_rst", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmp_bist.md
Name: cmp_bist

Overview:
Built-in self-test sequencer that drives the operand inputs of the ALU's WIDTH-bit greater-than comparator and checks its gt result.
- Sweeps every (a, b) operand pair and counts mismatches against an internal golden compare.
- Latches the first failing pair and reports pass/fail, for display on the Basys 3 LEDs/7-seg.
- Sits on the driving side of the comparator interface: it produces a/b and consumes gt.

Parameters:
WIDTH, 2, operand width in bits; the sweep covers 2^(2*WIDTH) pairs.
SETTLE, 1, cycles operands are held before gt is sampled; legal range 1..15.
ERR_W, 8, width of the saturating mismatch counter.

Ports:
clk  input  1  system clock; single clock domain, all logic on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  begin a sweep; sampled only in IDLE or DONE.
gt_in  input  1  gt output of the comparator under test (combinational from a_out/b_out).
a_out  output  WIDTH  operand a to the comparator (registered).
b_out  output  WIDTH  operand b to the comparator (registered).
busy  output  1  high while a sweep is running.
done  output  1  high in DONE until the next start or reset.
pass  output  1  valid when done=1; 1 if err_count==0.
err_count  output  ERR_W  mismatch count; saturates at 2^ERR_W-1.
fail_valid  output  1  a mismatch has been captured this sweep.
fail_a  output  WIDTH  a of the first mismatching pair.
fail_b  output  WIDTH  b of the first mismatching pair.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs go to 0 and the FSM goes to IDLE. Applies mid-sweep too; no sweep resumes after release until start.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1 at edge k:
  - a_out=b_out=0.
  - Clear err_count, fail_valid, fail_a, fail_b, pass and done.
  - Set busy=1, load settle counter with SETTLE-1, go to SETTLE.
- SETTLE: decrement the counter each cycle; at 0, go to CHECK. SETTLE lasts exactly SETTLE cycles.
- CHECK (one cycle): compare gt_in with the golden value exp = (a_out > b_out), unsigned, computed internally.
  - On mismatch: increment err_count (saturating).
  - On the first mismatch only: latch fail_a/fail_b = a_out/b_out and set fail_valid=1.
  - If {a_out,b_out} is the last pair (all ones): go to DONE, busy=0, done=1, pass=(final err_count==0), including any mismatch on the last pair.
  - Otherwise: increment {a_out,b_out} as one 2*WIDTH-bit counter (b is the inner/LSB part), reload the settle counter, go to SETTLE.
- Sweep order: (0,0),(0,1)...(0,max),(1,0)...(max,max). No wrap; the sweep ends at (max,max).
- Timing:
  - Each pair occupies SETTLE+1 cycles.
  - Pair i is checked at edge k+(i+1)(SETTLE+1).
  - done rises at edge k+2^(2W)(SETTLE+1). For W=2, SETTLE=1 that is k+32.
- DONE holds all result outputs and a_out/b_out=(max,max) until start or reset.
- start held high: in DONE it immediately begins a new sweep on the next edge.
- start while busy: ignored, no effect on the sequence.
- gt_in is sampled only in CHECK; its value at other times is don't-care.

Decomposition:
- Package cmp_bist_pkg: state enum (IDLE, SETTLE, CHECK, DONE) and the SETTLE counter width constant (4 bits).
- One natural sub-module, cmp_bist_sweep: the 2*WIDTH-bit operand counter with a last-pair flag.
- FSM, checker, error counter and fail capture stay in the top module.

Test Plan:
1. WIDTH=2, SETTLE=1, correct comparator, start pulse at edge k:
   - a/b step (0,0),(0,1)...(3,3), each held 2 cycles.
   - done=1 and busy=0 at k+32; pass=1, err_count=0, fail_valid=0.
2. gt_in stuck-at-0:
   - err_count=6, pass=0, fail_valid=1, fail_a=1, fail_b=0.
3. gt_in stuck-at-1:
   - err_count=10, pass=0, fail_a=0, fail_b=0.
4. start pulsed at cycles k+5 and k+20 during a sweep:
   - Ignored; done still at k+32.
   - A later start in DONE clears done/err_count and restarts from (0,0).
5. rst_n low for 1 cycle at pair (1,1):
   - All outputs 0 immediately, without waiting for a clock edge.
   - FSM stays in IDLE with a_out=b_out=0 until the next start.
6. ERR_W=2, gt_in stuck-at-1:
   - err_count saturates at 3; pass=0; fail_a=0, fail_b=0.
